// File: rtl/stopwatch_seg7_if.sv
// Bus between the stopwatch time counter and the 7-segment display stage.
//   t_mil_0..t_min_1 : BCD digits (ms units .. minute tens)
//   s_run, s_hld     : run / hold status
//   seg              : segments, bit0=a .. bit6=g
//   dp               : decimal point
//   dig              : digit enables, dig[i] selects slot i
// master drives the time/status side, slave is the display stage.
interface stopwatch_seg7_if;
   localparam int unsigned BCD_W = 4;
   localparam int unsigned SEG_W = 7;
   localparam int unsigned DIG_N = 7;

   logic [BCD_W-1:0] t_mil_0;
   logic [BCD_W-1:0] t_mil_1;
   logic [BCD_W-1:0] t_mil_2;
   logic [BCD_W-1:0] t_sec_0;
   logic [BCD_W-1:0] t_sec_1;
   logic [BCD_W-1:0] t_min_0;
   logic [BCD_W-1:0] t_min_1;
   logic             s_run;
   logic             s_hld;
   logic [SEG_W-1:0] seg;
   logic             dp;
   logic [DIG_N-1:0] dig;

   modport master (
      output t_mil_0, t_mil_1, t_mil_2, t_sec_0, t_sec_1, t_min_0, t_min_1,
      output s_run, s_hld,
      input  seg, dp, dig
   );

   modport slave (
      input  t_mil_0, t_mil_1, t_mil_2, t_sec_0, t_sec_1, t_min_0, t_min_1,
      input  s_run, s_hld,
      output seg, dp, dig
   );
endinterface

// File: rtl/stopwatch_seg7.sv
// Multiplexed 7-digit 7-segment driver for the stopwatch BCD outputs.
// Scans one digit per slot of DPN clocks (first clock of each slot blanked),
// snapshots all digits and status once per frame so the display never tears,
// and shows run/hold status on the slot-0 decimal point.
// Ports: clk, rst (async, active-high), bus (stopwatch_seg7_if.slave).
// Optional: define SEG7_LZB_EN to blank leading zeros on slots 6..4.
module stopwatch_seg7 #(
   parameter int unsigned DPN     = 8,
   parameter int unsigned DPL     = $clog2(DPN),
   parameter int unsigned BLL     = 4,
   parameter logic        SEG_POL = 1'b0,
   parameter logic        DIG_POL = 1'b0
) (
   input logic             clk,
   input logic             rst,
   stopwatch_seg7_if.slave bus
);
   localparam int unsigned ND    = 7;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned BCD_W = 4;

   logic [DPL-1:0]            cnt;
   logic [IDX_W-1:0]          idx;
   logic [BLL-1:0]            frm;
   logic [ND-1:0][BCD_W-1:0]  snap;
   logic                      snap_run;
   logic                      snap_hld;

   logic                      tick_c;
   logic                      frame_c;
   logic [BCD_W-1:0]          cur_c;
   logic [6:0]                pat_c;
   logic                      dp_raw_c;
   logic                      blank_c;
   logic [6:0]                seg_c;
   logic                      dp_c;
   logic [ND-1:0]             dig_c;

   assign tick_c  = (cnt == DPL'(DPN - 1));
   assign frame_c = tick_c && (idx == IDX_W'(ND - 1));

   // Digit currently being scanned
   always_comb begin
      cur_c = '0;
      case (idx)
         3'd0:    cur_c = snap[0];
         3'd1:    cur_c = snap[1];
         3'd2:    cur_c = snap[2];
         3'd3:    cur_c = snap[3];
         3'd4:    cur_c = snap[4];
         3'd5:    cur_c = snap[5];
         3'd6:    cur_c = snap[6];
         default: cur_c = '0;
      endcase
   end

   // BCD to active-high segments; invalid codes show a dash
   always_comb begin
      pat_c = 7'h40;
      case (cur_c)
         4'd0:    pat_c = 7'h3F;
         4'd1:    pat_c = 7'h06;
         4'd2:    pat_c = 7'h5B;
         4'd3:    pat_c = 7'h4F;
         4'd4:    pat_c = 7'h66;
         4'd5:    pat_c = 7'h6D;
         4'd6:    pat_c = 7'h7D;
         4'd7:    pat_c = 7'h07;
         4'd8:    pat_c = 7'h7F;
         4'd9:    pat_c = 7'h6F;
         default: pat_c = 7'h40;
      endcase
   end

   // Separators on slots 3/5; slot 0 steady while running, blinking on hold
   always_comb begin
      dp_raw_c = 1'b0;
      case (idx)
         3'd0:       dp_raw_c = snap_run & (~snap_hld | frm[BLL-1]);
         3'd3, 3'd5: dp_raw_c = 1'b1;
         default:    dp_raw_c = 1'b0;
      endcase
   end

`ifdef SEG7_LZB_EN
   logic lz6_c;
   logic lz5_c;
   logic lz4_c;

   // Blanking chains downward from the minute tens digit
   assign lz6_c = (snap[6] == '0);
   assign lz5_c = lz6_c && (snap[5] == '0);
   assign lz4_c = lz5_c && (snap[4] == '0);

   always_comb begin
      blank_c = 1'b0;
      case (idx)
         3'd4:    blank_c = lz4_c;
         3'd5:    blank_c = lz5_c;
         3'd6:    blank_c = lz6_c;
         default: blank_c = 1'b0;
      endcase
   end
`else
   assign blank_c = 1'b0;
`endif

   // Next output values; cnt==0 is the anti-ghost blanking clock
   always_comb begin
      seg_c = {7{~SEG_POL}};
      dp_c  = ~SEG_POL;
      dig_c = {ND{~DIG_POL}};
      if (cnt != '0) begin
         dig_c = (ND'(1) << idx) ^ {ND{~DIG_POL}};
         seg_c = blank_c ? {7{~SEG_POL}} : (pat_c ^ {7{~SEG_POL}});
         dp_c  = dp_raw_c ^ ~SEG_POL;
      end
   end

   // Scan counters, frame snapshot and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= '0;
         frm      <= '0;
         snap     <= '0;
         snap_run <= 1'b0;
         snap_hld <= 1'b0;
         bus.seg  <= {7{~SEG_POL}};
         bus.dp   <= ~SEG_POL;
         bus.dig  <= {ND{~DIG_POL}};
      end else begin
         cnt <= tick_c ? '0 : cnt + DPL'(1);
         if (tick_c)
            idx <= (idx == IDX_W'(ND - 1)) ? '0 : idx + IDX_W'(1);
         if (frame_c) begin
            snap     <= {bus.t_min_1, bus.t_min_0, bus.t_sec_1, bus.t_sec_0,
                         bus.t_mil_2, bus.t_mil_1, bus.t_mil_0};
            snap_run <= bus.s_run;
            snap_hld <= bus.s_hld;
            frm      <= frm + BLL'(1);
         end
         bus.seg <= seg_c;
         bus.dp  <= dp_c;
         bus.dig <= dig_c;
      end
   end
endmodule

// File: tb/tb_stopwatch_seg7.sv
// Scoreboard bench for stopwatch_seg7 (DPN=4, SEG_POL=1, DIG_POL=1).
// Stimulus pushes hand-decoded expected seg/dp/dig per clock into a queue;
// the monitor pops and compares after every clock edge and on reset assertion.
module tb_stopwatch_seg7;
   typedef struct packed {
      logic [6:0] dig;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   stopwatch_seg7_if bus_if ();

   stopwatch_seg7 #(
      .DPN     (4),
      .BLL     (4),
      .SEG_POL (1'b1),
      .DIG_POL (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   exp_t       q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         n_smp  = 0;
   logic [6:0] seg_tab [16];

   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a.dig = bus_if.dig;
            a.seg = bus_if.seg;
            a.dp  = bus_if.dp;
            n_chk++;
            if (a === e)
               n_pass++;
            else
               $display("FAIL sample %0d dig/seg/dp: got %h/%h/%b want %h/%h/%b",
                        n_smp, a.dig, a.seg, a.dp, e.dig, e.seg, e.dp);
            n_smp++;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
      $fatal(1);
   end

   task automatic push_blank(input int n);
      for (int k = 0; k < n; k++) q.push_back('0);
   endtask

   // Expected outputs for the first n clocks of a frame showing snapshot d
   task automatic push_frame(input logic [3:0] d [7], input logic dp0, input int n);
      exp_t       e;
      logic [6:0] blank_m;
      int         s;
      blank_m = '0;
`ifdef SEG7_LZB_EN
      blank_m[6] = (d[6] == 4'd0);
      blank_m[5] = blank_m[6] && (d[5] == 4'd0);
      blank_m[4] = blank_m[5] && (d[4] == 4'd0);
`endif
      for (int k = 0; k < n; k++) begin
         s = k / 4;
         e = '0;
         if ((k % 4) != 0) begin
            e.dig = 7'(1 << s);
            e.seg = blank_m[s] ? 7'h00 : seg_tab[d[s]];
            e.dp  = (s == 3 || s == 5) ? 1'b1 : ((s == 0) ? dp0 : 1'b0);
         end
         q.push_back(e);
      end
   endtask

   task automatic set_in(input logic [3:0] d [7], input logic run, input logic hld);
      bus_if.t_mil_0 = d[0];
      bus_if.t_mil_1 = d[1];
      bus_if.t_mil_2 = d[2];
      bus_if.t_sec_0 = d[3];
      bus_if.t_sec_1 = d[4];
      bus_if.t_min_0 = d[5];
      bus_if.t_min_1 = d[6];
      bus_if.s_run   = run;
      bus_if.s_hld   = hld;
   endtask

   // Advance n rising edges, then park on the following falling edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin : stim
      logic [3:0] zero [7];
      logic [3:0] d_a  [7];
      logic [3:0] d_b  [7];
      int         wait_cnt;

      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      zero = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      // mil_0 .. min_1 = 6,7,8,9,9,5,0  (display 05:99.876 style)
      d_a  = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd5, 4'd0};
      d_b  = d_a;
      d_b[0] = 4'd12;

      rst = 1'b0;
      set_in(zero, 1'b0, 1'b0);
      #1;
      // Reset assertion plus two clocks held in reset: all inactive
      push_blank(3);
      rst = 1'b1;
      step(2);
      rst = 1'b0;

      // Frame 0: snapshot zero; inputs change mid-frame and must not show yet
      push_frame(zero, 1'b0, 28);
      step(14);
      set_in(d_a, 1'b0, 1'b0);
      step(14);

      // Frame 1: new digits; invalid mil_0 and run set mid-frame
      push_frame(d_a, 1'b0, 28);
      step(14);
      set_in(d_b, 1'b1, 1'b0);
      step(14);

      // Frame 2: dash on slot 0, run point steady; hold set mid-frame
      push_frame(d_b, 1'b1, 28);
      step(14);
      set_in(d_b, 1'b1, 1'b1);
      step(14);

      // Frames 3..18 on hold: point lit only while frame count is 8..15
      for (int f = 3; f <= 18; f++) begin
         push_frame(d_b, ((f % 16) >= 8) ? 1'b1 : 1'b0, 28);
         step(28);
      end

      // Frame 19: reset asynchronously during slot 4
      push_frame(d_b, 1'b0, 18);
      step(18);
      push_blank(3);
      rst = 1'b1;
      step(2);
      rst = 1'b0;

      // Scanning restarts at slot 0 with a cleared snapshot
      push_frame(zero, 1'b0, 28);
      step(28);
      // Hold with blink phase 0: slot-0 point off
      push_frame(d_b, 1'b0, 28);
      step(28);

      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 8) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      n_chk++;
      if (q.size() == 0)
         n_pass++;
      else
         $display("FAIL drain: %0d expected samples left, want 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/stopwatch_seg7.md
Name: stopwatch_seg7

Overview:
- Downstream display stage for the stopwatch BCD time outputs.
- Drives a 7-digit multiplexed 7-segment display from:
  - the seven BCD digits t_mil_0..t_min_1;
  - the run/hold status bits s_run and s_hld.
- Scans one digit at a time and snapshots all inputs once per frame, so the display never tears.
- Shows status on the decimal points.

Parameters:
- DPN, 8: clock periods per digit slot; minimum 2.
- DPL, $clog2(DPN): width of the slot counter.
- BLL, 4: width of the frame counter; its MSB is the blink phase.
- SEG_POL, 1'b0: segment/dp polarity; 1 = active-high, 0 = active-low.
- DIG_POL, 1'b0: digit-enable polarity; 1 = active-high, 0 = active-low.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- t_mil_0, t_mil_1, t_mil_2, t_sec_0, t_sec_1, t_min_0, t_min_1  input  4 each  BCD digits
- s_run  input  1  run status
- s_hld  input  1  hold status
- seg  output  7  segments; bit0=a ... bit6=g
- dp  output  1  decimal point
- dig  output  7  digit enables; dig[i] selects slot i

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
- Effect of reset (including mid-frame): clears all state immediately.
  - Slot counter cnt = 0, digit index idx = 0, frame counter = 0.
  - Snapshot registers = 0.
  - seg = {7{~SEG_POL}}, dp = ~SEG_POL, dig = {7{~DIG_POL}} (all inactive).
- Slot counter cnt:
  - Counts 0..DPN-1, then wraps to 0.
  - tick = (cnt == DPN-1).
- Digit index idx:
  - Increments on every tick; wraps from 6 to 0.
  - Slot mapping: 0=mil_0, 1=mil_1, 2=mil_2, 3=sec_0, 4=sec_1, 5=min_0, 6=min_1.
- Frame boundary: tick with idx==6.
  - All seven digits, s_run and s_hld are latched into snapshot registers.
  - The frame counter increments and wraps modulo 2^BLL.
  - Inputs are never sampled at any other time.
- Outputs are registered and computed from the pre-edge cnt, idx and snapshot, so they lag by one clock.
  - If cnt==0 (blanking/anti-ghost cycle): dig all inactive, seg inactive, dp inactive.
  - Otherwise: dig = one-hot(idx), seg = decode(snapshot digit[idx]), dp as defined below.
  - Each digit is therefore active DPN-1 clocks per slot. Frame period = 7*DPN clocks.
- Decode, active-high hex before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Invalid codes 10..15 display 40 (a dash).
  - Output value = pattern XOR {7{~SEG_POL}}.
- Decimal point (active-high value before polarity is applied):
  - idx 3 and idx 5: 1 (separators for s.ms and m.s).
  - idx 0: snap_run & (~snap_hld | blink). blink = frame counter MSB, so the point is steady while running and blinks while on hold.
  - All other slots: 0.
- Simultaneous events: a digit input changing on the same edge as the frame boundary is captured with its pre-edge value. The new value appears from the next frame.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Slot 6 blanks (seg inactive, dp unchanged) when its snapshot value is 0.
  - Slot 5 blanks when its value is 0 and slot 6 is blanked.
  - Slot 4 blanks when its value is 0 and slot 5 is blanked.
  - Slots 0..3 are never blanked.
  - dig still scans normally for blanked slots.
- Undefined: all slots are always decoded; no blanking logic is synthesized.

Test Plan (run with DPN=4, SEG_POL=1, DIG_POL=1):
- Reset, then 28 clocks with all inputs = 0:
  - dig sequence 01, 02, 04 ... 40, each held 3 clocks and preceded by 1 clock of 00.
  - seg = 3F throughout the first frame (snapshot is 0).
- Inputs set to 5:9:9.8:7:6 (min_1..mil_0 = 0,5,9,9,8,7,6) mid-frame:
  - The current frame still shows old values.
  - From the next frame, slot 0 shows 7D and slot 6 shows 3F; slot 3 has dp=1.
- t_mil_0=12 (invalid code): slot 0 shows seg=40.
- s_run=1, s_hld=0: slot-0 dp=1 every frame.
- s_hld=1: slot-0 dp alternates in blocks of 8 frames.
- rst asserted during slot 4: dig=00, seg=00 and dp=0 asynchronously; after release, scanning restarts at slot 0 with the snapshot = 0.
- With SEG7_LZB_EN defined and inputs 0,0,0,3,... (min_1..sec_0):
  - Slots 6, 5 and 4 show seg=00.
  - Slot 3 shows 4F.
  - Setting min_1=1 un-blanks slots 5 and 4 (both show 3F).
